// File: rtl/rst_sequencer.sv
// Reset sequencer: holds NUM_DOMAINS resets until clock lock, releases them in ascending order.
// Optional watchdog reset source is built when URC_RST_WDT_EN is defined.
module rst_sequencer #(
    parameter int SYSCLK_FREQ    = 100_000_000,
    parameter int NUM_DOMAINS    = 4,
    parameter int STAGE_DELAY_US = 10,
    parameter int DEBOUNCE_US    = 1000,
    parameter int SYNC_STAGES    = 2,
    parameter int WDT_TIMEOUT_US = 100_000
) (
    input  logic                   clk_100M,
    input  logic                   sysrstn,
    input  logic                   locked,
    input  logic                   ext_rst_req,
    input  logic                   sw_rst_req,
    input  logic                   wdt_kick,
    output logic [NUM_DOMAINS-1:0] dom_rstn,
    output logic                   all_released,
    output logic [2:0]             rst_cause
);

    localparam int CYC_PER_US      = SYSCLK_FREQ / 1_000_000;
    localparam int STAGE_CYCLES    = CYC_PER_US * STAGE_DELAY_US;
    localparam int DEBOUNCE_CYCLES = CYC_PER_US * DEBOUNCE_US;
    localparam int SCW             = $clog2(STAGE_CYCLES + 1);
    localparam int DBW             = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IW              = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [SCW-1:0] STAGE_LAST = SCW'(STAGE_CYCLES - 1);
    localparam logic [DBW-1:0] DEB_MAX    = DBW'(DEBOUNCE_CYCLES);
    localparam logic [IW-1:0]  IDX_LAST   = IW'(NUM_DOMAINS - 1);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_RELEASE,
        ST_RUN,
        ST_ASSERT
    } state_t;

    typedef enum logic [2:0] {
        CAUSE_POR       = 3'd0,
        CAUSE_LOCK_LOSS = 3'd1,
        CAUSE_EXT       = 3'd2,
        CAUSE_SW        = 3'd3,
        CAUSE_WDT       = 3'd4
    } cause_t;

    state_t               r_state;
    logic [SCW-1:0]       r_cnt;
    logic [IW-1:0]        r_idx;
    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic [SYNC_STAGES-1:0] r_ext_sync;
    logic [DBW-1:0]       r_deb_cnt;

    logic   w_locked_s;
    logic   w_ext_s;
    logic   w_ext_evt;
    logic   w_wdt_expire;
    logic   w_evt;
    cause_t w_cause;

    always_ff @(posedge clk_100M or negedge sysrstn) begin
        if (!sysrstn) begin
            r_lock_sync <= '0;
            r_ext_sync  <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], locked};
            r_ext_sync  <= {r_ext_sync[SYNC_STAGES-2:0], ext_rst_req};
        end
    end

    assign w_locked_s = r_lock_sync[SYNC_STAGES-1];
    assign w_ext_s    = r_ext_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_100M or negedge sysrstn) begin
        if (!sysrstn) begin
            r_deb_cnt <= '0;
        end else if (!w_ext_s) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt != DEB_MAX) begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    assign w_ext_evt = (r_deb_cnt == DEB_MAX);

`ifdef URC_RST_WDT_EN
    localparam int WDT_CYCLES = CYC_PER_US * WDT_TIMEOUT_US;
    localparam int WW         = $clog2(WDT_CYCLES + 1);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

    logic [WW-1:0] r_wdt_cnt;

    always_ff @(posedge clk_100M or negedge sysrstn) begin
        if (!sysrstn) begin
            r_wdt_cnt <= '0;
        end else if (r_state != ST_RUN || wdt_kick) begin
            r_wdt_cnt <= '0;
        end else if (r_wdt_cnt != WDT_LAST) begin
            r_wdt_cnt <= r_wdt_cnt + 1'b1;
        end
    end

    // A kick landing on the expiry cycle suppresses the reset.
    assign w_wdt_expire = (r_state == ST_RUN) && (r_wdt_cnt == WDT_LAST) && !wdt_kick;
`else
    logic w_unused_wdt;
    assign w_unused_wdt = wdt_kick ^ (WDT_TIMEOUT_US == 0);
    assign w_wdt_expire = 1'b0;
`endif

    always_comb begin
        w_evt   = 1'b0;
        w_cause = CAUSE_POR;
        if (r_state == ST_WAIT_LOCK || r_state == ST_RELEASE || r_state == ST_RUN) begin
            if (!w_locked_s && r_state != ST_WAIT_LOCK) begin
                w_evt   = 1'b1;
                w_cause = CAUSE_LOCK_LOSS;
            end else if (w_ext_evt) begin
                w_evt   = 1'b1;
                w_cause = CAUSE_EXT;
            end else if (sw_rst_req) begin
                w_evt   = 1'b1;
                w_cause = CAUSE_SW;
            end else if (w_wdt_expire) begin
                w_evt   = 1'b1;
                w_cause = CAUSE_WDT;
            end
        end
    end

    always_ff @(posedge clk_100M or negedge sysrstn) begin
        if (!sysrstn) begin
            r_state      <= ST_HOLD;
            r_cnt        <= '0;
            r_idx        <= '0;
            dom_rstn     <= '0;
            all_released <= 1'b0;
            rst_cause    <= CAUSE_POR;
        end else if (w_evt) begin
            r_state      <= ST_ASSERT;
            r_cnt        <= '0;
            r_idx        <= '0;
            dom_rstn     <= '0;
            all_released <= 1'b0;
            rst_cause    <= w_cause;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    r_state <= ST_WAIT_LOCK;
                    r_cnt   <= '0;
                end
                ST_WAIT_LOCK: begin
                    dom_rstn <= '0;
                    if (!w_locked_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt == STAGE_LAST) begin
                        r_state <= ST_RELEASE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == STAGE_LAST) begin
                        dom_rstn[r_idx] <= 1'b1;
                        r_cnt           <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_state      <= ST_RUN;
                            all_released <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    dom_rstn     <= '1;
                    all_released <= 1'b1;
                end
                ST_ASSERT: begin
                    dom_rstn <= '0;
                    // Count saturates so a held button keeps the domains in reset.
                    if (r_cnt != STAGE_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (!w_ext_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= ST_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: timeline model of the reset rules plus directed scenarios.
// Define URC_RST_WDT_EN for both files to exercise the watchdog path.
module tb_rst_sequencer;

    localparam int N    = 4;
    localparam int S    = 10;
    localparam int D    = 20;
    localparam int SYNC = 2;
    localparam int HN   = 16384;
`ifdef URC_RST_WDT_EN
    localparam int W    = 50;
`endif

    logic       clk = 1'b0;
    logic       sysrstn = 1'b1;
    logic       locked = 1'b1;
    logic       ext_rst_req = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       wdt_kick = 1'b0;
    logic [3:0] dom_rstn;
    logic       all_released;
    logic [2:0] rst_cause;

    int errors = 0;
    int checks = 0;
    bit kick_en = 1'b1;
`ifdef URC_RST_WDT_EN
    int last_kick_cyc = 0;
`endif

    rst_sequencer #(
        .SYSCLK_FREQ    (10_000_000),
        .NUM_DOMAINS    (N),
        .STAGE_DELAY_US (1),
        .DEBOUNCE_US    (2),
        .SYNC_STAGES    (SYNC),
        .WDT_TIMEOUT_US (5)
    ) dut (
        .clk_100M     (clk),
        .sysrstn      (sysrstn),
        .locked       (locked),
        .ext_rst_req  (ext_rst_req),
        .sw_rst_req   (sw_rst_req),
        .wdt_kick     (wdt_kick),
        .dom_rstn     (dom_rstn),
        .all_released (all_released),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: phases described by run lengths and elapsed time since phase entry.
    typedef enum {M_IDLE, M_LOCKWAIT, M_RAMP, M_UP, M_HELD} mphase_t;
    mphase_t    ph;
    int         cyc, entry, wait_run, ext_run, kick_ref, first_rel, exp_cause;
    logic [3:0] exp_dom;
    logic       exp_all;
    bit         hist_lock [HN];
    bit         hist_ext  [HN];

    task automatic model_reset();
        ph = M_IDLE; cyc = 0; entry = 0; wait_run = 0; ext_run = 0;
        kick_ref = 0; first_rel = -1; exp_cause = 0; exp_dom = '0; exp_all = 1'b0;
    endtask

    task automatic model_step();
        bit ls, es, ev_ext, wdt;
        int k, cause;
        cyc++;
        hist_lock[cyc % HN] = locked;
        hist_ext[cyc % HN]  = ext_rst_req;
        ls = (cyc > SYNC) ? hist_lock[(cyc - SYNC) % HN] : 1'b0;
        es = (cyc > SYNC) ? hist_ext[(cyc - SYNC) % HN] : 1'b0;
        ev_ext  = (ext_run >= D);
        ext_run = es ? ((ext_run < D) ? ext_run + 1 : D) : 0;
        wdt = 1'b0;
`ifdef URC_RST_WDT_EN
        wdt = (ph == M_UP) && (cyc - kick_ref == W) && !wdt_kick;
`endif
        cause = 0;
        if (ph == M_LOCKWAIT || ph == M_RAMP || ph == M_UP) begin
            if (ph != M_LOCKWAIT && !ls) cause = 1;
            else if (ev_ext)             cause = 2;
            else if (sw_rst_req)         cause = 3;
            else if (wdt)                cause = 4;
        end
        if (cause != 0) begin
            ph = M_HELD; entry = cyc; exp_cause = cause; exp_dom = '0; exp_all = 1'b0;
        end else begin
            case (ph)
                M_IDLE: begin ph = M_LOCKWAIT; wait_run = 0; end
                M_LOCKWAIT: begin
                    wait_run = ls ? wait_run + 1 : 0;
                    if (wait_run == S) begin ph = M_RAMP; entry = cyc; end
                end
                M_RAMP: begin
                    k = (cyc - entry) / S;
                    exp_dom = 4'((1 << k) - 1);
                    if (k == N) begin ph = M_UP; exp_all = 1'b1; kick_ref = cyc; end
                end
                M_UP: if (wdt_kick) kick_ref = cyc;
                M_HELD: if (cyc - entry >= S && !es) begin ph = M_LOCKWAIT; wait_run = 0; end
                default: ;
            endcase
        end
        if (exp_dom != 0 && first_rel < 0) first_rel = cyc;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge sysrstn);
            if (!sysrstn) model_reset();
            else          model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("dom_rstn", int'(dom_rstn), int'(exp_dom));
            check("all_released", int'(all_released), int'(exp_all));
            check("rst_cause", int'(rst_cause), exp_cause);
        end
    end

    initial begin
        forever begin
            repeat (39) @(negedge clk);
            if (kick_en) begin
                wdt_kick = 1'b1;
`ifdef URC_RST_WDT_EN
                last_kick_cyc = cyc + 1;
`endif
            end
            @(negedge clk);
            wdt_kick = 1'b0;
        end
    end

    task automatic wait_dom(input logic [3:0] val, input int budget, input string name, output int n);
        n = 0;
        while (dom_rstn !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dom_rstn !== val) check({name, "_timeout"}, int'(dom_rstn), int'(val));
    endtask

    task automatic wait_all(input logic val, input int budget, input string name, output int n);
        n = 0;
        while (all_released !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (all_released !== val) check({name, "_timeout"}, int'(all_released), int'(val));
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout at t=%0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n, n2, n3;
        #1 sysrstn = 1'b0;
        repeat (5) @(negedge clk);
        check("por_dom", int'(dom_rstn), 0);
        check("por_all", int'(all_released), 0);
        check("por_cause", int'(rst_cause), 0);
        sysrstn = 1'b1;

        // Power-up with lock present throughout.
        wait_dom(4'b0001, 200, "pu_rel0", n);
        check("pu_first_release_cycle", cyc, 22);
        check("model_first_release", first_rel, 22);
        wait_dom(4'b0011, 20, "pu_rel1", n);
        check("pu_rel1_cycle", cyc, 32);
        wait_all(1'b1, 200, "pu_run", n);
        check("pu_run_cycle", cyc, 52);
        check("pu_dom_all", int'(dom_rstn), 15);
        check("pu_cause", int'(rst_cause), 0);

        // One-cycle lock loss in RUN.
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        wait_dom(4'b0000, 20, "ll_assert", n2);
        check("ll_latency", 1 + n2, 3);
        check("ll_cause", int'(rst_cause), 1);
        wait_all(1'b1, 200, "ll_rerun", n3);
        check("ll_rerun_latency", 1 + n2 + n3, 63);

        // Software reset, then sysrstn mid-ASSERT clears everything including the cause.
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        check("sw1_dom", int'(dom_rstn), 0);
        repeat (3) @(negedge clk);
        check("sw1_cause", int'(rst_cause), 3);
        #2 sysrstn = 1'b0;
        #1;
        check("async_dom", int'(dom_rstn), 0);
        check("async_all", int'(all_released), 0);
        check("async_cause", int'(rst_cause), 0);
        repeat (3) @(negedge clk);
        sysrstn = 1'b1;

        // Lock glitch in WAIT_LOCK at counter 7.
        repeat (7) @(negedge clk);
        locked = 1'b0;
        repeat (3) @(negedge clk);
        locked = 1'b1;
        wait_dom(4'b0001, 200, "gl_rel0", n);
        check("gl_first_release_cycle", cyc, 32);
        check("model_gl_first_release", first_rel, 32);
        wait_all(1'b1, 200, "gl_run", n);
        check("gl_run_cycle", cyc, 62);

        // Bouncing button never reaches the debounce threshold.
        for (int i = 0; i < 10; i++) begin
            ext_rst_req = 1'b1;
            repeat (5) @(negedge clk);
            ext_rst_req = 1'b0;
            repeat (5) @(negedge clk);
        end
        check("bounce_all", int'(all_released), 1);
        check("bounce_cause", int'(rst_cause), 0);

        // Held button: reset after debounce, held in reset until release.
        ext_rst_req = 1'b1;
        wait_dom(4'b0000, 40, "ext_assert", n);
        check("ext_latency", n, 23);
        check("ext_cause", int'(rst_cause), 2);
        repeat (50 - n) @(negedge clk);
        check("ext_held_dom", int'(dom_rstn), 0);
        ext_rst_req = 1'b0;
        wait_all(1'b1, 200, "ext_rerun", n2);
        check("ext_rerun_latency", n2, 53);

        // sw pulse coincident with first ext_evt: EXT wins.
        ext_rst_req = 1'b1;
        repeat (22) @(negedge clk);
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        check("simul_dom", int'(dom_rstn), 0);
        check("simul_cause", int'(rst_cause), 2);
        ext_rst_req = 1'b0;
        wait_all(1'b1, 200, "simul_rerun", n);

        // sw alone.
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        check("sw2_dom", int'(dom_rstn), 0);
        check("sw2_cause", int'(rst_cause), 3);
        wait_all(1'b1, 200, "sw2_rerun", n);

`ifdef URC_RST_WDT_EN
        repeat (200) @(negedge clk);
        check("wdt_kicked_all", int'(all_released), 1);
        kick_en = 1'b0;
        wait_all(1'b0, 200, "wdt_expire", n);
        check("wdt_expire_delay", cyc - last_kick_cyc, 50);
        check("wdt_cause", int'(rst_cause), 4);
        wait_all(1'b1, 200, "wdt_rerun", n);
`else
        kick_en = 1'b0;
        repeat (200) @(negedge clk);
        check("nowdt_all", int'(all_released), 1);
        check("nowdt_cause", int'(rst_cause), 3);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
